snake_input_arbiter: RTL and testbench

// Sits between the board buttons/switches and the snake game core, on the game clock.

---
 rtl/snake_input_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_snake_input_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_input_arbiter.sv
// snake_input_arbiter
// Synchronises and debounces the board direction buttons and the pause/restart
// switches, round-robin arbitrates direction presses and queues legal turns in a
// small FIFO that the game core pops once per snake step.
module snake_input_arbiter #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_up,
  input  logic                              i_down,
  input  logic                              i_left,
  input  logic                              i_right,
  input  logic                              i_pause,
  input  logic                              i_restart,
  input  logic                              i_step,
  output logic [1:0]                        o_dir,
  output logic                              o_pause,
  output logic                              o_restart,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level
);

  // Input vector bit order: 0 up, 1 right, 2 down, 3 left (matches the direction
  // encoding so a pending bit index is its direction code), 4 pause, 5 restart.
  localparam int NIN = 6;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [1:0]    DIR_RIGHT = 2'b01;

  // Input conditioning state
  logic [NIN-1:0] raw_s;
  logic [NIN-1:0] sync1_q;
  logic [NIN-1:0] sync2_q;
  logic [NIN-1:0] deb_q;
  logic [NIN-1:0] deb_d;
  logic [NIN-1:0] deb_prev_q;
  logic [CW-1:0]  cnt_q [NIN];
  logic [CW-1:0]  cnt_d [NIN];

  // Arbitration / queue state
  logic [3:0]     pending_q;
  logic [3:0]     pending_d;
  logic [1:0]     rr_q;
  logic [1:0]     rr_d;
  logic [1:0]     dir_q;
  logic [1:0]     dir_d;
  logic [LW-1:0]  level_q;
  logic [LW-1:0]  level_d;
  logic [1:0]     fifo_q [FIFO_DEPTH];
  logic [1:0]     fifo_d [FIFO_DEPTH];
  logic           restart_q;

  // Decoded control
  logic           pause_s;
  logic           restart_s;
  logic [3:0]     press_s;
  logic           grant_valid_s;
  logic [1:0]     grant_s;
  logic [1:0]     idx_s;
  logic [3:0]     grant_oh_s;
  logic           arb_grant_s;
  logic [1:0]     ref_dir_s;
  logic           pop_s;
  logic           full_s;
  logic           accept_s;

  assign raw_s     = {i_restart, i_pause, i_left, i_down, i_right, i_up};
  assign pause_s   = deb_q[4];
  assign restart_s = deb_q[5] & ~deb_prev_q[5];
  // Presses are masked while paused, so they are never recorded as pending.
  assign press_s   = deb_q[3:0] & ~deb_prev_q[3:0] & {4{~pause_s}};

  assign o_dir     = dir_q;
  assign o_pause   = deb_q[4];
  assign o_restart = restart_q;
  assign o_level   = level_q;

  // Debounce next state: a level flips only after the synced input has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = CNT_ZERO;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = CNT_ZERO;
      end
    end
  end

  // Synchroniser, debounce counters and edge-detect history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= {NIN{1'b0}};
      sync2_q    <= {NIN{1'b0}};
      deb_q      <= {NIN{1'b0}};
      deb_prev_q <= {NIN{1'b0}};
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      sync1_q    <= raw_s;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Round-robin search over pending bits starting at rr_q (next-in-line direction).
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 2'b00;
    idx_s         = 2'b00;
    for (int k = 0; k < 4; k++) begin
      idx_s = rr_q + 2'(k);
      if (!grant_valid_s && pending_q[idx_s]) begin
        grant_valid_s = 1'b1;
        grant_s       = idx_s;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Reference direction is the newest queued turn, or the live direction when the queue is empty.
  always_comb begin
    ref_dir_s = dir_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (level_q == LW'(i + 1)) begin
        ref_dir_s = fifo_q[i];
      end else begin
        ref_dir_s = ref_dir_s;
      end
    end
  end

  // Grant acceptance: no repeat, no reversal, and room in the queue unless a pop frees a slot.
  always_comb begin
    grant_oh_s  = 4'b0001 << grant_s;
    arb_grant_s = grant_valid_s & ~pause_s & ~restart_s;
    pop_s       = i_step & ~pause_s & ~restart_s & (level_q != LVL_ZERO);
    full_s      = (level_q == LVL_FULL);
    accept_s    = arb_grant_s
                  && (grant_s != ref_dir_s)
                  && (grant_s != (ref_dir_s ^ 2'b10))
                  && (!full_s || pop_s);
  end

  // Next state of queue, direction, pending bits and RR pointer; restart flushes everything.
  always_comb begin
    fifo_d    = fifo_q;
    level_d   = level_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    rr_d      = rr_q;
    if (pop_s) begin
      dir_d = fifo_q[0];
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        fifo_d[i] = fifo_q[i + 1];
      end
      level_d = level_q - LVL_ONE;
    end else begin
      dir_d = dir_q;
    end
    if (accept_s) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (LW'(i) == level_d) begin
          fifo_d[i] = grant_s;
        end else begin
          fifo_d[i] = fifo_d[i];
        end
      end
      level_d = level_d + LVL_ONE;
    end else begin
      level_d = level_d;
    end
    if (arb_grant_s) begin
      pending_d = pending_q & ~grant_oh_s;
      rr_d      = grant_s + 2'b01;
    end else begin
      pending_d = pending_q;
    end
    pending_d = pending_d | press_s;
    if (restart_s) begin
      level_d   = LVL_ZERO;
      dir_d     = DIR_RIGHT;
      pending_d = 4'b0000;
    end else begin
      level_d = level_d;
    end
  end

  // Arbiter, FIFO and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 4'b0000;
      rr_q      <= 2'b00;
      dir_q     <= DIR_RIGHT;
      level_q   <= LVL_ZERO;
      restart_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= 2'b00;
      end
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      dir_q     <= dir_d;
      level_q   <= level_d;
      restart_q <= restart_s;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

endmodule

// File: tb/tb_snake_input_arbiter.sv
// Testbench for snake_input_arbiter: directed scenarios followed by random
// stimulus, compared every cycle against a queue-based behavioural model.
module tb_snake_input_arbiter;
  localparam int DEB   = 4;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_up = 1'b0, i_down = 1'b0, i_left = 1'b0, i_right = 1'b0;
  logic       i_pause = 1'b0, i_restart = 1'b0, i_step = 1'b0;
  logic [1:0] o_dir;
  logic       o_pause, o_restart;
  logic [1:0] o_level;

  int checks = 0;
  int errors = 0;

  // Reference model state (index 0 up, 1 right, 2 down, 3 left, 4 pause, 5 restart)
  logic [5:0] m_s1, m_s2, m_deb, m_debq;
  int         m_cnt [6];
  logic [3:0] m_pend;
  int         m_rr;
  logic [1:0] m_q [$];
  logic [1:0] m_dir;
  logic       m_restart;

  snake_input_arbiter #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right),
    .i_pause(i_pause), .i_restart(i_restart), .i_step(i_step),
    .o_dir(o_dir), .o_pause(o_pause), .o_restart(o_restart), .o_level(o_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the current inputs, clock the DUT, compare.
  task automatic tick();
    logic [5:0] raw;
    logic       paused, rs_edge, got, pop, acc;
    logic [1:0] g, r;
    int         idx;
    raw = {i_restart, i_pause, i_left, i_down, i_right, i_up};
    if (!rst_n) begin
      m_s1 = 6'd0; m_s2 = 6'd0; m_deb = 6'd0; m_debq = 6'd0;
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
      m_pend = 4'd0; m_rr = 0; m_q.delete(); m_dir = 2'b01; m_restart = 1'b0;
    end else begin
      paused  = m_deb[4];
      rs_edge = m_deb[5] && !m_debq[5];
      got = 1'b0; g = 2'b00;
      if (!paused && !rs_edge) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_rr + k) % 4;
          if (!got && m_pend[idx]) begin got = 1'b1; g = 2'(idx); end
        end
      end
      pop = i_step && !paused && !rs_edge && (m_q.size() > 0);
      r   = (m_q.size() > 0) ? m_q[$] : m_dir;
      acc = got && (g != r) && (g != (r ^ 2'b10)) && ((m_q.size() < DEPTH) || pop);
      if (got) begin m_pend[g] = 1'b0; m_rr = (int'(g) + 1) % 4; end
      for (int d = 0; d < 4; d++)
        if (m_deb[d] && !m_debq[d] && !paused) m_pend[d] = 1'b1;
      if (pop) m_dir = m_q.pop_front();
      if (acc) m_q.push_back(g);
      if (rs_edge) begin m_q.delete(); m_pend = 4'd0; m_dir = 2'b01; end
      m_restart = rs_edge;
      m_debq = m_deb;
      for (int i = 0; i < 6; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          if (m_cnt[i] == DEB - 1) begin m_deb[i] = m_s2[i]; m_cnt[i] = 0; end
          else m_cnt[i] = m_cnt[i] + 1;
        end else m_cnt[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    @(posedge clk);
    #1;
    chk("dir",     o_dir,     m_dir);
    chk("level",   o_level,   m_q.size());
    chk("pause",   o_pause,   m_deb[4]);
    chk("restart", o_restart, m_restart);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input int d, input logic v);
    case (d)
      0: i_up    = v;
      1: i_right = v;
      2: i_down  = v;
      default: i_left = v;
    endcase
  endtask

  // Hold one direction long enough to register, then release and let it settle.
  task automatic press(input int d);
    set_btn(d, 1'b1); ticks(10);
    set_btn(d, 1'b0); ticks(10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ticks(2); rst_n = 1'b1;
  endtask

  initial begin
    #1;
    // Reset state
    do_reset();
    chk("rst_dir", o_dir, 2'b01);
    chk("rst_level", o_level, 2'd0);
    chk("rst_pause", o_pause, 1'b0);
    chk("rst_restart", o_restart, 1'b0);

    // 1: held up reaches the queue after 8 cycles, step makes it current
    i_up = 1'b1;
    ticks(7);
    chk("t1_level_c7", o_level, 2'd0);
    tick();
    chk("t1_level_c8", o_level, 2'd1);
    ticks(2);
    i_up = 1'b0; i_step = 1'b1; tick(); i_step = 1'b0;
    chk("t1_dir_up", o_dir, 2'b00);
    chk("t1_level0", o_level, 2'd0);
    ticks(10);

    // 2: 3-cycle glitch is dropped
    i_left = 1'b1; ticks(3); i_left = 1'b0; ticks(12);
    chk("t2_glitch", o_level, 2'd0);

    // 3: reversal and repeat rejected from o_dir=right
    do_reset();
    press(3); press(1);
    chk("t3_level", o_level, 2'd0);

    // 4: up and down together; up first, down rejected as reversal of tail
    do_reset();
    i_up = 1'b1; i_down = 1'b1; ticks(12);
    chk("t4_level", o_level, 2'd1);
    chk("t4_dir", o_dir, 2'b01);
    i_up = 1'b0; i_down = 1'b0; ticks(10);
    i_step = 1'b1; tick(); i_step = 1'b0;
    chk("t4_dir_up", o_dir, 2'b00);

    // 5: fill queue, overflow dropped, step coincides with a grant
    do_reset();
    press(0); press(3);
    chk("t5_full", o_level, 2'd2);
    press(2);
    chk("t5_drop", o_level, 2'd2);
    i_up = 1'b1; ticks(7);
    i_step = 1'b1; tick(); i_step = 1'b0;
    chk("t5_pp_dir", o_dir, 2'b00);
    chk("t5_pp_level", o_level, 2'd2);
    i_up = 1'b0; ticks(10);
    i_step = 1'b1; tick(); i_step = 1'b0;
    chk("t5_pop_left", o_dir, 2'b11);
    i_step = 1'b1; tick(); i_step = 1'b0;
    chk("t5_pop_up", o_dir, 2'b00);

    // 6: restart flush, then pause freezes queue, restart overrides pause
    press(3); press(0);
    chk("t6_level2", o_level, 2'd2);
    i_restart = 1'b1; ticks(7);
    chk("t6_rst_pulse", o_restart, 1'b1);
    chk("t6_rst_level", o_level, 2'd0);
    chk("t6_rst_dir", o_dir, 2'b01);
    tick();
    chk("t6_rst_once", o_restart, 1'b0);
    ticks(4); i_restart = 1'b0; ticks(10);
    press(0);
    chk("t6_q1", o_level, 2'd1);
    i_pause = 1'b1; ticks(8);
    chk("t6_paused", o_pause, 1'b1);
    i_step = 1'b1; tick(); i_step = 1'b0;
    press(3);
    chk("t6_hold_lvl", o_level, 2'd1);
    chk("t6_hold_dir", o_dir, 2'b01);
    i_restart = 1'b1; ticks(7);
    chk("t6_pr_pulse", o_restart, 1'b1);
    chk("t6_pr_level", o_level, 2'd0);
    i_restart = 1'b0; i_pause = 1'b0; ticks(12);
    chk("t6_unpaused", o_pause, 1'b0);

    // Random phase against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) i_up    = ~i_up;
      if ($urandom_range(7) == 0) i_right = ~i_right;
      if ($urandom_range(7) == 0) i_down  = ~i_down;
      if ($urandom_range(7) == 0) i_left  = ~i_left;
      if ($urandom_range(63) == 0) i_pause   = ~i_pause;
      if ($urandom_range(47) == 0) i_restart = ~i_restart;
      i_step = ($urandom_range(3) == 0);
      rst_n  = ($urandom_range(699) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
